// File: rtl/dio_ts_pkg.sv
// Shared types and register-map constants for the DIO timestamp event FIFO.
package dio_ts_pkg;

  typedef struct packed {
    logic [39:0] tai;
    logic [27:0] cycles;
  } t_dio_ts;

  localparam logic [1:0] ADR_CSR    = 2'd0;
  localparam logic [1:0] ADR_SEC_LO = 2'd1;
  localparam logic [1:0] ADR_SEC_HI = 2'd2;
  localparam logic [1:0] ADR_CYC    = 2'd3;

  localparam int CSR_EN        = 0;
  localparam int CSR_IRQ_EN    = 1;
  localparam int CSR_CLR       = 2;
  localparam int CSR_COUNT_LSB = 8;
  localparam int CSR_FULL      = 16;
  localparam int CSR_EMPTY     = 17;
  localparam int CSR_OVF       = 18;
  localparam int CSR_NOTIME    = 19;

endpackage

// File: rtl/dio_ts_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; data_o always shows the head entry.
module dio_ts_sync_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_eff, pop_eff;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign pop_eff  = pop_i & ~empty_o & ~clear_i;
  assign push_eff = push_i & ~clear_i & (~full_o | pop_eff);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dio_ts_event_fifo.sv
// Timestamps rising edges of one DIO input against WR time and queues them for
// software readout over a Wishbone classic slave, with a level IRQ while pending.
module dio_ts_event_fifo
  import dio_ts_pkg::*;
#(
  parameter int g_fifo_depth = 16
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        pulse_i,
  input  logic [39:0] tm_tai_i,
  input  logic [27:0] tm_cycles_i,
  input  logic        tm_valid_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        irq_o
);

  localparam int AW = (g_fifo_depth > 1) ? $clog2(g_fifo_depth) : 1;

  logic        pulse_d_q;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic        notime_q, notime_d;
  logic        irq_q;
  logic        ack_q;
  logic [1:0]  req_adr_q;
  logic        req_we_q;
  logic [4:0]  req_wd_q;   // {NOTIME_W1C, OVF_W1C, CLR, IRQ_EN, EN}

  logic        edge_det, push, pop, clr, wr_csr, wb_req;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  t_dio_ts     fifo_in, head;
  logic [31:0] csr_word, rdata;
  logic        unused_ok;

  assign unused_ok = ^{wb_sel_i, wb_dat_i[31:20], wb_dat_i[17:3]};

  assign edge_det = en_q & pulse_i & ~pulse_d_q;
  assign push     = edge_det & tm_valid_i;
  assign fifo_in  = '{tai: tm_tai_i, cycles: tm_cycles_i};

  // Requests are latched on the strobe; their side effects land on the edge ending the ack cycle.
  assign wb_req = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_csr = ack_q & req_we_q & (req_adr_q == ADR_CSR);
  assign clr    = wr_csr & req_wd_q[2];
  assign pop    = ack_q & ~req_we_q & (req_adr_q == ADR_CYC);

  dio_ts_sync_fifo #(
    .WIDTH ($bits(t_dio_ts)),
    .DEPTH (g_fifo_depth)
  ) u_fifo (
    .clk_i   (clk_sys_i),
    .rst_n_i (rst_n_i),
    .clear_i (clr),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (fifo_in),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    notime_d = notime_q;
    if (wr_csr) begin
      en_d     = req_wd_q[0];
      irq_en_d = req_wd_q[1];
      if (req_wd_q[3]) ovf_d    = 1'b0;
      if (req_wd_q[4]) notime_d = 1'b0;
    end
    // A new event wins over a simultaneous write-1-to-clear.
    if (push & fifo_full & ~(pop & ~fifo_empty) & ~clr) ovf_d = 1'b1;
    if (edge_det & ~tm_valid_i)                         notime_d = 1'b1;
  end

  always_comb begin
    csr_word                = '0;
    csr_word[CSR_EN]        = en_q;
    csr_word[CSR_IRQ_EN]    = irq_en_q;
    csr_word[CSR_COUNT_LSB +: 8] = 8'(fifo_count);
    csr_word[CSR_FULL]      = fifo_full;
    csr_word[CSR_EMPTY]     = fifo_empty;
    csr_word[CSR_OVF]       = ovf_q;
    csr_word[CSR_NOTIME]    = notime_q;

    rdata = '0;
    case (req_adr_q)
      ADR_CSR:    rdata = csr_word;
      ADR_SEC_LO: if (!fifo_empty) rdata = head.tai[31:0];
      ADR_SEC_HI: if (!fifo_empty) rdata = {24'd0, head.tai[39:32]};
      ADR_CYC:    if (!fifo_empty) rdata = {4'd0, head.cycles};
      default:    rdata = '0;
    endcase
  end

  assign wb_dat_o = ack_q ? rdata : '0;
  assign wb_ack_o = ack_q;
  assign irq_o    = irq_q;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pulse_d_q <= 1'b0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      notime_q  <= 1'b0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      req_adr_q <= '0;
      req_we_q  <= 1'b0;
      req_wd_q  <= '0;
    end else begin
      pulse_d_q <= pulse_i;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      notime_q  <= notime_d;
      irq_q     <= irq_en_q & ~fifo_empty;
      ack_q     <= wb_req;
      if (wb_req) begin
        req_adr_q <= wb_adr_i;
        req_we_q  <= wb_we_i;
        req_wd_q  <= {wb_dat_i[19], wb_dat_i[18], wb_dat_i[2:0]};
      end
    end
  end

endmodule
